uart_pkt_parse: RTL and testbench
=================================

Name: uart_pkt_parse

Overview:
Consumes the byte stream produced by the UART receiver (rx_data plus the one-cycle po_flag strobe) and parses framed packets. It emits a command strobe and packs payload bytes into 16-bit words for the SDRAM write path. It verifies an XOR checksum and flags packet completion or error. A byte-gap timeout returns it to idle when a link stalls mid-packet.

Parameters:
HDR0, 8'h55, first header byte
HDR1, 8'hAA, second header byte
TIMEOUT_CYC, 50000, sclk cycles allowed between bytes inside a packet; set to 200 for simulation
TO_W, 16, timeout counter width; must satisfy 2**TO_W > TIMEOUT_CYC

Ports:
sclk  in  1  system clock
s_rst_n  in  1  reset
rx_data  in  8  received byte; valid only while po_flag=1
po_flag  in  1  one-cycle byte-valid strobe from UART receiver
cmd_out  out  8  command byte of current packet; held until the next packet's CMD byte
cmd_vld  out  1  one-cycle pulse: cmd_out updated
wr_data  out  16  packed payload word
wr_en  out  1  one-cycle pulse: wr_data valid
pkt_done  out  1  one-cycle pulse: checksum matched
pkt_err  out  1  one-cycle pulse: checksum mismatch or timeout
busy  out  1  high in every state except IDLE

Behaviour:
- Reset is s_rst_n, asynchronous, active-low. Clock is sclk.
- All outputs reset to 0. FSM resets to IDLE. Length, checksum, byte-phase and timeout registers reset to 0.
- Packet format: HDR0, HDR1, CMD, LEN_L, LEN_H, LEN payload bytes, CHK.
- CHK is the XOR of CMD, LEN_L, LEN_H and all payload bytes. LEN is 16-bit unsigned.
- The FSM advances only on cycles with po_flag=1.
- State transitions:
  - IDLE: byte==HDR0 -> S_HDR1; any other byte is ignored.
  - S_HDR1: byte==HDR1 -> S_CMD; byte==HDR0 -> stay in S_HDR1 (resync); any other byte -> IDLE.
  - S_CMD: latch cmd_out, pulse cmd_vld on the next cycle, chk=byte -> S_LEN_L.
  - S_LEN_L: latch low byte -> S_LEN_H.
  - S_LEN_H: latch high byte; LEN==0 -> S_CHK, otherwise -> S_PAY with the remaining-byte counter set to LEN.
  - S_PAY: XOR each byte into chk and decrement the counter. Last byte -> S_CHK.
  - S_CHK: compare against chk, then -> IDLE.
- Payload packing:
  - Even byte (phase 0) is stored as the high byte.
  - Odd byte (phase 1) completes the word {hi, byte}; wr_en pulses on the cycle after that byte's po_flag.
  - If LEN is odd, the last byte is emitted as {byte, 8'h00*} with wr_en on the cycle after it (*pad is 8'h00).
- Completion latency: pkt_done or pkt_err is asserted on the cycle after the CHK byte's po_flag, for exactly one cycle.
- pkt_done and pkt_err are mutually exclusive.
- Payload words are already written before CHK arrives. Downstream discards the packet on pkt_err.
- Timeout:
  - The counter clears on every po_flag and in IDLE. Otherwise it increments while busy.
  - On reaching TIMEOUT_CYC: pulse pkt_err, go to IDLE, and discard any half-packed byte (no wr_en).
- po_flag in the same cycle as timeout expiry: the byte wins. The counter clears and the FSM processes the byte.
- A HDR0 byte inside the payload is treated as data; there is no escaping.
- Reset asserted mid-packet: immediate return to IDLE with all pulses low and no partial word emitted.
- busy=1 in every state except IDLE, combinational from the state register.

Decomposition:
- Shared package uart_pkt_pkg holds:
  - the state enum (IDLE, S_HDR1, S_CMD, S_LEN_L, S_LEN_H, S_PAY, S_CHK);
  - the HDR0/HDR1 default constants;
  - the simulation/synthesis TIMEOUT_CYC values.
- One sub-module, byte_timeout:
  - inputs: sclk, s_rst_n, clr, en;
  - output: expired (one-cycle pulse);
  - parameterised by TIMEOUT_CYC and TO_W.
- FSM, packer and checksum logic stay in uart_pkt_parse.

Test Plan:
- Good packet 55 AA 01 04 00 11 22 33 44 41 -> cmd_vld with cmd_out=01; wr_en twice (1122, then 3344); pkt_done one cycle after the 41 byte; pkt_err never asserted.
- Odd length 55 AA 02 03 00 AA BB CC DC -> wr_data AABB, then CC00 (two wr_en pulses); pkt_done.
- Bad checksum: the first packet with its last byte changed to 40 -> both words still written; pkt_err pulses; pkt_done stays 0; busy=0 afterwards.
- Resync and zero length: 13 55 55 AA 03 00 00 03 -> 13 ignored; resync on the second 55; cmd_out=03; no wr_en; pkt_done.
- Timeout: 55 AA 01 04 00 11, then silence -> pkt_err exactly TIMEOUT_CYC cycles after the 11 byte; no wr_en for the orphan 11. A following good packet parses normally.
- Reset mid-payload: assert s_rst_n=0 after 55 AA 01 02 00 11 -> all outputs 0 and busy=0. After release, a full packet yields pkt_done.

Source files
------------

// File: rtl/uart_pkt_pkg.sv
// Shared state encoding and default constants for the UART packet parser.
package uart_pkt_pkg;

   typedef enum logic [2:0] {
      IDLE,
      S_HDR1,
      S_CMD,
      S_LEN_L,
      S_LEN_H,
      S_PAY,
      S_CHK
   } pkt_state_t;

   localparam logic [7:0]  HDR0_DEF        = 8'h55;
   localparam logic [7:0]  HDR1_DEF        = 8'hAA;
   localparam int unsigned TIMEOUT_CYC_SYN = 50000;
   localparam int unsigned TIMEOUT_CYC_SIM = 200;
   localparam int unsigned TO_W_DEF        = 16;

endpackage

// File: rtl/uart_pkt_parse_byte_timeout.sv
// Inter-byte gap watchdog: pulses expired when a packet stalls too long between bytes.
module byte_timeout
   import uart_pkt_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_SYN,
   parameter int unsigned TO_W        = TO_W_DEF
) (
   input  logic sclk,
   input  logic s_rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   // cnt lags the elapsed cycle count by one and the error flag downstream is
   // registered, so firing at TIMEOUT_CYC-2 lands pkt_err TIMEOUT_CYC cycles after the byte.
   localparam logic [TO_W-1:0] FIRE_AT = TO_W'(TIMEOUT_CYC - 2);

   logic [TO_W-1:0] cnt;

   assign expired = en && !clr && (cnt == FIRE_AT);

   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         cnt <= '0;
      end else if (clr || expired) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + TO_W'(1);
      end
   end

endmodule

// File: rtl/uart_pkt_parse.sv
// Framed packet parser for the UART byte stream: command strobe, 16-bit payload
// packing for the SDRAM write path, XOR checksum and inter-byte timeout.
module uart_pkt_parse
   import uart_pkt_pkg::*;
#(
   parameter logic [7:0]  HDR0        = HDR0_DEF,
   parameter logic [7:0]  HDR1        = HDR1_DEF,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_SYN,
   parameter int unsigned TO_W        = TO_W_DEF
) (
   input  logic        sclk,
   input  logic        s_rst_n,
   input  logic [7:0]  rx_data,
   input  logic        po_flag,
   output logic [7:0]  cmd_out,
   output logic        cmd_vld,
   output logic [15:0] wr_data,
   output logic        wr_en,
   output logic        pkt_done,
   output logic        pkt_err,
   output logic        busy
);

   pkt_state_t  state;
   logic [7:0]  len_l;
   logic [7:0]  chk;
   logic [7:0]  hi_byte;
   logic [15:0] rem;
   logic        phase;
   logic [15:0] len_full;
   logic        to_clr;
   logic        to_exp;

   assign busy     = (state != IDLE);
   assign to_clr   = po_flag || (state == IDLE);
   assign len_full = {rx_data, len_l};

   byte_timeout #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .TO_W        (TO_W)
   ) u_byte_timeout (
      .sclk    (sclk),
      .s_rst_n (s_rst_n),
      .clr     (to_clr),
      .en      (busy),
      .expired (to_exp)
   );

   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         state    <= IDLE;
         cmd_out  <= '0;
         cmd_vld  <= 1'b0;
         wr_data  <= '0;
         wr_en    <= 1'b0;
         pkt_done <= 1'b0;
         pkt_err  <= 1'b0;
         len_l    <= '0;
         chk      <= '0;
         hi_byte  <= '0;
         rem      <= '0;
         phase    <= 1'b0;
      end else begin
         cmd_vld  <= 1'b0;
         wr_en    <= 1'b0;
         pkt_done <= 1'b0;
         pkt_err  <= 1'b0;

         // A byte arriving on the expiry cycle takes priority over the timeout.
         if (po_flag) begin
            case (state)
               IDLE: begin
                  if (rx_data == HDR0) state <= S_HDR1;
               end
               S_HDR1: begin
                  if (rx_data == HDR1)      state <= S_CMD;
                  else if (rx_data != HDR0) state <= IDLE;
               end
               S_CMD: begin
                  cmd_out <= rx_data;
                  cmd_vld <= 1'b1;
                  chk     <= rx_data;
                  state   <= S_LEN_L;
               end
               S_LEN_L: begin
                  len_l <= rx_data;
                  chk   <= chk ^ rx_data;
                  state <= S_LEN_H;
               end
               S_LEN_H: begin
                  chk   <= chk ^ rx_data;
                  phase <= 1'b0;
                  if (len_full == 16'h0000) begin
                     state <= S_CHK;
                  end else begin
                     rem   <= len_full;
                     state <= S_PAY;
                  end
               end
               S_PAY: begin
                  chk <= chk ^ rx_data;
                  rem <= rem - 16'd1;
                  if (!phase) begin
                     hi_byte <= rx_data;
                     phase   <= 1'b1;
                     // Odd-length tail: flush the lone byte with a zero pad.
                     if (rem == 16'd1) begin
                        wr_data <= {rx_data, 8'h00};
                        wr_en   <= 1'b1;
                        phase   <= 1'b0;
                     end
                  end else begin
                     wr_data <= {hi_byte, rx_data};
                     wr_en   <= 1'b1;
                     phase   <= 1'b0;
                  end
                  if (rem == 16'd1) state <= S_CHK;
               end
               S_CHK: begin
                  if (rx_data == chk) pkt_done <= 1'b1;
                  else                pkt_err  <= 1'b1;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end else if (to_exp) begin
            pkt_err <= 1'b1;
            phase   <= 1'b0;
            state   <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_uart_pkt_parse.sv
// Directed bench for uart_pkt_parse: packet-level reference model checked every cycle,
// plus hand-computed per-scenario expectations.
module tb_uart_pkt_parse;

   localparam int unsigned T = 200;

   logic        sclk    = 1'b0;
   logic        s_rst_n = 1'b1;
   logic        po_flag = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic [7:0]  cmd_out;
   logic        cmd_vld;
   logic [15:0] wr_data;
   logic        wr_en;
   logic        pkt_done;
   logic        pkt_err;
   logic        busy;

   uart_pkt_parse #(
      .HDR0        (8'h55),
      .HDR1        (8'hAA),
      .TIMEOUT_CYC (T),
      .TO_W        (16)
   ) dut (
      .sclk     (sclk),
      .s_rst_n  (s_rst_n),
      .rx_data  (rx_data),
      .po_flag  (po_flag),
      .cmd_out  (cmd_out),
      .cmd_vld  (cmd_vld),
      .wr_data  (wr_data),
      .wr_en    (wr_en),
      .pkt_done (pkt_done),
      .pkt_err  (pkt_err),
      .busy     (busy)
   );

   always #5 sclk = ~sclk;

   int          n_assert = 0;
   int          n_fail   = 0;
   int unsigned cyc      = 0;

   always @(posedge sclk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: header hunt, then the packet body is collected in a queue and
   // every output is derived from byte positions within it.
   int          mode = 0;   // 0 hunting, 1 saw first header byte, 2 inside packet
   int          gap  = 0;
   logic [7:0]  pk[$];
   logic [7:0]  e_cmd     = 8'h00;
   logic        e_cmd_vld = 1'b0;
   logic        e_wr_en   = 1'b0;
   logic        e_done    = 1'b0;
   logic        e_err     = 1'b0;
   logic        e_busy    = 1'b0;
   logic [15:0] e_wr      = 16'h0000;

   task automatic model_byte(input logic [7:0] b);
      int n, len, p;
      logic [7:0] x;
      pk.push_back(b);
      n = pk.size();
      if (n == 1) begin
         e_cmd     = b;
         e_cmd_vld = 1'b1;
         return;
      end
      if (n < 3) return;
      len = int'({pk[2], pk[1]});
      if (n == len + 4) begin
         x = 8'h00;
         for (int i = 0; i < n - 1; i++) x = x ^ pk[i];
         if (x == b) e_done = 1'b1;
         else        e_err  = 1'b1;
         mode = 0;
      end else if (n > 3) begin
         p = n - 4;
         if (p % 2 == 1) begin
            e_wr    = {pk[n-2], b};
            e_wr_en = 1'b1;
         end else if (p == len - 1) begin
            e_wr    = {b, 8'h00};
            e_wr_en = 1'b1;
         end
      end
   endtask

   always @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         mode = 0; gap = 0; pk.delete();
         e_cmd = 8'h00; e_cmd_vld = 1'b0; e_wr_en = 1'b0; e_done = 1'b0;
         e_err = 1'b0; e_busy = 1'b0; e_wr = 16'h0000;
      end else begin
         e_cmd_vld = 1'b0; e_wr_en = 1'b0; e_done = 1'b0; e_err = 1'b0;
         if (po_flag) begin
            gap = 0;
            if (mode == 0) begin
               if (rx_data == 8'h55) mode = 1;
            end else if (mode == 1) begin
               if (rx_data == 8'hAA) begin
                  mode = 2;
                  pk.delete();
               end else if (rx_data != 8'h55) begin
                  mode = 0;
               end
            end else begin
               model_byte(rx_data);
            end
         end else if (mode != 0) begin
            gap++;
            // error must be visible exactly T cycles after the last byte
            if (gap + 1 == T) begin
               e_err = 1'b1;
               mode  = 0;
            end
         end
         e_busy = (mode != 0);
      end
   end

   logic [15:0] wlog[$];
   int          ndone    = 0;
   int          nerr     = 0;
   int unsigned done_cyc = 0;
   int unsigned err_cyc  = 0;

   always @(negedge sclk) begin
      check("busy",     32'(busy),     32'(e_busy));
      check("cmd_out",  32'(cmd_out),  32'(e_cmd));
      check("cmd_vld",  32'(cmd_vld),  32'(e_cmd_vld));
      check("wr_en",    32'(wr_en),    32'(e_wr_en));
      if (e_wr_en) check("wr_data", 32'(wr_data), 32'(e_wr));
      check("pkt_done", 32'(pkt_done), 32'(e_done));
      check("pkt_err",  32'(pkt_err),  32'(e_err));
      if (wr_en) wlog.push_back(wr_data);
      if (pkt_done) begin ndone++; done_cyc = cyc; end
      if (pkt_err)  begin nerr++;  err_cyc  = cyc; end
   end

   logic [7:0]  stim[$];
   int unsigned last_cyc = 0;

   // Caller is at a negedge; byte is presented for exactly one cycle.
   task automatic send(input logic [7:0] b, input int idle);
      po_flag  = 1'b1;
      rx_data  = b;
      last_cyc = cyc;
      @(negedge sclk);
      po_flag  = 1'b0;
      rx_data  = 8'h55;
      repeat (idle) @(negedge sclk);
   endtask

   task automatic send_stim(input int last_idle);
      for (int i = 0; i < stim.size(); i++)
         send(stim[i], (i == stim.size() - 1) ? last_idle : (i % 3));
   endtask

   task automatic start();
      wlog.delete();
      ndone = 0;
      nerr  = 0;
      @(negedge sclk);
   endtask

   task automatic settle();
      repeat (4) @(negedge sclk);
      #1;
   endtask

   function automatic logic [15:0] wword(input int i);
      if (i < wlog.size()) return wlog[i];
      return 16'hxxxx;
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 s_rst_n = 1'b0;
      repeat (3) @(negedge sclk);
      #1;
      check("rst_busy",  32'(busy),     32'd0);
      check("rst_cmd",   32'(cmd_out),  32'd0);
      check("rst_wr_en", 32'(wr_en),    32'd0);
      check("rst_wdata", 32'(wr_data),  32'd0);
      check("rst_done",  32'(pkt_done), 32'd0);
      check("rst_err",   32'(pkt_err),  32'd0);
      s_rst_n = 1'b1;

      // good packet
      start();
      stim = {8'h55, 8'hAA, 8'h01, 8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h41};
      send_stim(0);
      settle();
      check("good_nwords", 32'(wlog.size()), 32'd2);
      check("good_w0",     32'(wword(0)),    32'h1122);
      check("good_w1",     32'(wword(1)),    32'h3344);
      check("good_cmd",    32'(cmd_out),     32'h01);
      check("good_done",   32'(ndone),       32'd1);
      check("good_err",    32'(nerr),        32'd0);
      check("good_lat",    32'(done_cyc - last_cyc), 32'd1);

      // odd length
      start();
      stim = {8'h55, 8'hAA, 8'h02, 8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDC};
      send_stim(0);
      settle();
      check("odd_w0",   32'(wword(0)), 32'hAABB);
      check("odd_w1",   32'(wword(1)), 32'hCC00);
      check("odd_done", 32'(ndone),    32'd1);
      check("odd_cmd",  32'(cmd_out),  32'h02);

      // bad checksum
      start();
      stim = {8'h55, 8'hAA, 8'h01, 8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h40};
      send_stim(0);
      settle();
      check("bad_nwords", 32'(wlog.size()), 32'd2);
      check("bad_err",    32'(nerr),        32'd1);
      check("bad_done",   32'(ndone),       32'd0);
      check("bad_busy",   32'(busy),        32'd0);

      // resync on repeated header, zero length
      start();
      stim = {8'h13, 8'h55, 8'h55, 8'hAA, 8'h03, 8'h00, 8'h00, 8'h03};
      send_stim(0);
      settle();
      check("rs_nwords", 32'(wlog.size()), 32'd0);
      check("rs_cmd",    32'(cmd_out),     32'h03);
      check("rs_done",   32'(ndone),       32'd1);

      // timeout after orphan payload byte
      start();
      stim = {8'h55, 8'hAA, 8'h01, 8'h04, 8'h00, 8'h11};
      send_stim(T + 10);
      #1;
      check("to_err",    32'(nerr),               32'd1);
      check("to_lat",    32'(err_cyc - last_cyc), 32'(T));
      check("to_nwords", 32'(wlog.size()),        32'd0);
      check("to_busy",   32'(busy),               32'd0);
      start();
      stim = {8'h55, 8'hAA, 8'h01, 8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h41};
      send_stim(0);
      settle();
      check("to_next_done", 32'(ndone),    32'd1);
      check("to_next_w1",   32'(wword(1)), 32'h3344);

      // byte arriving on the expiry cycle wins
      start();
      stim = {8'h55, 8'hAA, 8'h01, 8'h02, 8'h00};
      send_stim(0);
      send(8'h11, T - 2);
      send(8'h22, 1);
      send(8'h30, 0);
      settle();
      check("edge_err",  32'(nerr),     32'd0);
      check("edge_done", 32'(ndone),    32'd1);
      check("edge_w0",   32'(wword(0)), 32'h1122);

      // reset mid-payload
      start();
      stim = {8'h55, 8'hAA, 8'h01, 8'h02, 8'h00, 8'h11};
      send_stim(0);
      #1;
      check("mr_busy_pre", 32'(busy), 32'd1);
      #1 s_rst_n = 1'b0;
      #1;
      check("mr_busy",  32'(busy),     32'd0);
      check("mr_cmd",   32'(cmd_out),  32'd0);
      check("mr_wr_en", 32'(wr_en),    32'd0);
      check("mr_done",  32'(pkt_done), 32'd0);
      check("mr_err",   32'(pkt_err),  32'd0);
      @(negedge sclk);
      #2 s_rst_n = 1'b1;
      start();
      stim = {8'h55, 8'hAA, 8'h01, 8'h02, 8'h00, 8'h11, 8'h22, 8'h30};
      send_stim(0);
      settle();
      check("mr_next_done", 32'(ndone),    32'd1);
      check("mr_next_err",  32'(nerr),     32'd0);
      check("mr_next_w0",   32'(wword(0)), 32'h1122);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
